parity_engine: RTL and testbench

PARITY_ENGINE -- requirements
Module: parity_engine

---
 rtl/parity_engine.sv | 147 ++++++++++++++
 tb/tb_parity_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_engine.sv
// rtl/parity_engine.sv - parity generator for TX bytes and serial parity checker with error counter
module parity_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     parity_enable,
  input  logic [1:0]               parity_type,
  input  logic                     data_valid,
  input  logic [DATA_WIDTH-1:0]    parallel_data,
  output logic                     parity_bit,
  output logic                     parity_valid,
  input  logic                     frame_start,
  input  logic                     bit_valid,
  input  logic                     serial_bit,
  output logic                     busy,
  output logic                     check_done,
  output logic                     parity_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  input  logic                     err_count_clear
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             lat_enable;
  logic [1:0]       lat_type;
  logic             result_next;
  logic             done_entry;

  // Map the XOR of the data bits onto the selected parity mode
  function automatic logic apply_mode(input logic xor_in, input logic [1:0] mode);
    case (mode)
      2'b00:   apply_mode = xor_in;
      2'b01:   apply_mode = ~xor_in;
      2'b10:   apply_mode = 1'b1;
      default: apply_mode = 1'b0;
    endcase
  endfunction

  // TX generator: register parity of the offered byte, fully independent of the checker
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit   <= 1'b0;
      parity_valid <= 1'b0;
    end else begin
      parity_valid <= data_valid & parity_enable;
      if (data_valid && parity_enable) begin
        parity_bit <= apply_mode(^parallel_data, parity_type);
      end
    end
  end

  // Checker state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Checker next-state logic; frame_start restarts from any state
  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = S_DATA;
    end else begin
      case (state)
        S_IDLE:   state_next = S_IDLE;
        S_DATA: begin
          if (bit_valid && (bit_cnt == LAST_BIT)) begin
            state_next = lat_enable ? S_PARITY : S_DONE;
          end
        end
        S_PARITY: begin
          if (bit_valid) begin
            state_next = S_DONE;
          end
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Checker outputs decoded from the current state
  always_comb begin
    busy       = (state != S_IDLE);
    check_done = (state == S_DONE);
  end

  // Result of the frame being closed: only a received parity bit can flag an error
  always_comb begin
    result_next = 1'b0;
    if (state == S_PARITY) begin
      result_next = serial_bit ^ apply_mode(acc, lat_type);
    end
    done_entry = (state_next == S_DONE) && (state != S_DONE);
  end

  // Checker datapath: mode latch, running XOR, bit counter and held result
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= 1'b0;
      bit_cnt      <= '0;
      lat_enable   <= 1'b0;
      lat_type     <= 2'b00;
      parity_error <= 1'b0;
    end else if (frame_start) begin
      acc        <= 1'b0;
      bit_cnt    <= '0;
      lat_enable <= parity_enable;
      lat_type   <= parity_type;
    end else begin
      if ((state == S_DATA) && bit_valid) begin
        acc     <= acc ^ serial_bit;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (done_entry) begin
        parity_error <= result_next;
      end
    end
  end

  // Saturating error counter, bumped while DONE shows an error; clear has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_count_clear) begin
      err_count <= '0;
    end else if ((state == S_DONE) && parity_error && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_engine.sv
// tb/tb_parity_engine.sv - self-checking bench for parity_engine against a behavioural model
module tb_parity_engine;

  logic       clk;
  logic       reset;
  logic       parity_enable;
  logic [1:0] parity_type;
  logic       data_valid;
  logic [7:0] parallel_data;
  logic       parity_bit;
  logic       parity_valid;
  logic       frame_start;
  logic       bit_valid;
  logic       serial_bit;
  logic       busy;
  logic       check_done;
  logic       parity_error;
  logic [1:0] err_count;
  logic       err_count_clear;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  parity_engine #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .data_valid(data_valid), .parallel_data(parallel_data),
    .parity_bit(parity_bit), .parity_valid(parity_valid),
    .frame_start(frame_start), .bit_valid(bit_valid), .serial_bit(serial_bit),
    .busy(busy), .check_done(check_done), .parity_error(parity_error),
    .err_count(err_count), .err_count_clear(err_count_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are observed at the following falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference parity from a population count of the ones in the data
  function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] mode);
    int ones;
    ones = $countones(d);
    case (mode)
      2'b00:   return logic'(ones % 2 == 1);
      2'b01:   return logic'(ones % 2 == 0);
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_bit(input logic b);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) begin
      bit_valid  = 1'b0;
      serial_bit = 1'($urandom);
      tick();
    end
    bit_valid  = 1'b1;
    serial_bit = b;
    tick();
    bit_valid  = 1'b0;
  endtask

  task automatic run_frame(input logic en, input logic [1:0] typ, input logic [7:0] data,
                           input logic pbit, input logic clr);
    logic exp_err;
    exp_err       = en ? (pbit != ref_parity(data, typ)) : 1'b0;
    parity_enable = en;
    parity_type   = typ;
    frame_start   = 1'b1;
    tick();
    frame_start   = 1'b0;
    parity_enable = 1'($urandom);
    parity_type   = 2'($urandom);
    check("busy_in_frame", 16'(busy), 16'd1);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (en) send_bit(pbit);
    check("check_done_pulse", 16'(check_done), 16'd1);
    check("parity_error", 16'(parity_error), 16'(exp_err));
    err_count_clear = clr;
    bit_valid       = 1'b1;
    serial_bit      = 1'($urandom);
    tick();
    err_count_clear = 1'b0;
    if (clr) model_cnt = 0;
    else if (exp_err && model_cnt < 3) model_cnt++;
    check("check_done_one_cycle", 16'(check_done), 16'd0);
    check("idle_after_done", 16'(busy), 16'd0);
    check("parity_error_held", 16'(parity_error), 16'(exp_err));
    check("err_count", 16'(err_count), 16'(model_cnt));
    tick();
    bit_valid = 1'b0;
    check("bit_valid_ignored_in_idle", 16'(busy), 16'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] t;
    logic       e;
    logic       v;
    logic       exp_bit;
    logic       exp_valid;

    reset = 1'b1; parity_enable = 1'b0; parity_type = 2'b00; data_valid = 1'b0;
    parallel_data = 8'h00; frame_start = 1'b0; bit_valid = 1'b0; serial_bit = 1'b0;
    err_count_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_parity_bit", 16'(parity_bit), 16'd0);
    check("rst_parity_valid", 16'(parity_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_check_done", 16'(check_done), 16'd0);
    check("rst_parity_error", 16'(parity_error), 16'd0);
    check("rst_err_count", 16'(err_count), 16'd0);

    // Directed generate: 0xA5 even then odd
    parity_enable = 1'b1; parity_type = 2'b00; parallel_data = 8'hA5; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("gen_even_bit", 16'(parity_bit), 16'd0);
    check("gen_even_valid", 16'(parity_valid), 16'd1);
    tick();
    check("gen_valid_pulse", 16'(parity_valid), 16'd0);
    parity_type = 2'b01; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("gen_odd_bit", 16'(parity_bit), 16'd1);
    check("gen_odd_valid", 16'(parity_valid), 16'd1);
    tick();
    check("gen_hold_bit", 16'(parity_bit), 16'd1);

    // Randomized generate against the population-count model
    exp_bit = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom); t = 2'($urandom); e = 1'($urandom); v = 1'($urandom);
      parallel_data = d; parity_type = t; parity_enable = e; data_valid = v;
      tick();
      exp_valid = v & e;
      if (exp_valid) exp_bit = ref_parity(d, t);
      check("gen_rand_valid", 16'(parity_valid), 16'(exp_valid));
      check("gen_rand_bit", 16'(parity_bit), 16'(exp_bit));
    end
    data_valid = 1'b0;

    // Check pass, check fail, mark-mode fail
    run_frame(1'b1, 2'b01, 8'h07, 1'b0, 1'b0);
    run_frame(1'b1, 2'b01, 8'h07, 1'b1, 1'b0);
    run_frame(1'b1, 2'b10, 8'h07, 1'b0, 1'b0);

    // Abort after three data bits, then a full clean frame
    parity_enable = 1'b1; parity_type = 2'b00; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      check("abort_no_done", 16'(check_done), 16'd0);
    end
    run_frame(1'b1, 2'b00, 8'h3C, 1'b0, 1'b0);

    // No-parity frame closes right after the eighth bit
    run_frame(1'b0, 2'b01, 8'hFF, 1'b1, 1'b0);

    // Saturation then clear coincident with a failing DONE
    for (int n = 0; n < 4; n++) run_frame(1'b1, 2'b00, 8'h01, 1'b0, 1'b0);
    check("err_saturated", 16'(err_count), 16'd3);
    run_frame(1'b1, 2'b11, 8'h55, 1'b1, 1'b1);
    check("err_cleared", 16'(err_count), 16'd0);

    // Randomized frames
    for (int n = 0; n < 12; n++) begin
      run_frame(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0));
    end

    // Build up errors then reset while waiting for the parity bit
    run_frame(1'b1, 2'b00, 8'h01, 1'b0, 1'b0);
    parity_enable = 1'b1; parity_type = 2'b00; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    check("in_parity_busy", 16'(busy), 16'd1);
    reset = 1'b1; bit_valid = 1'b1; serial_bit = 1'b1;
    tick();
    reset = 1'b0; bit_valid = 1'b0;
    model_cnt = 0;
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_err_count", 16'(err_count), 16'(model_cnt));
    check("midrst_check_done", 16'(check_done), 16'd0);
    check("midrst_parity_error", 16'(parity_error), 16'd0);
    tick();
    check("midrst_no_late_done", 16'(check_done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
